// File: rtl/ws2812_pkg.sv
// ============================================================================
// ws2812_pkg : FSM state encoding, colour-order codes and ns/us -> cycle helpers
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_BIT_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_LATCH    = 3'd4
  } ws_state_e;

  localparam int unsigned COLOR_ORDER_ASIS = 0;
  localparam int unsigned COLOR_ORDER_GRB  = 1;

  // Rounded to nearest cycle, never shorter than one cycle.
  function automatic int unsigned ns_to_cyc(input longint unsigned clk_hz,
                                            input longint unsigned ns);
    longint unsigned cyc;
    cyc = (clk_hz / 64'd1000 * ns + 64'd500_000) / 64'd1_000_000;
    if (cyc < 64'd1) cyc = 64'd1;
    return cyc[31:0];
  endfunction

  function automatic int unsigned us_to_cyc(input longint unsigned clk_hz,
                                            input longint unsigned us);
    longint unsigned cyc;
    cyc = clk_hz / 64'd1_000_000 * us;
    if (cyc < 64'd1) cyc = 64'd1;
    return cyc[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
// ============================================================================
// ws2812_bit_encoder : pixel shift register plus high/low phase timer
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ws2812_bit_encoder #(
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned T0H_CYC      = 11,
  parameter int unsigned T0L_CYC      = 23,
  parameter int unsigned T1H_CYC      = 23,
  parameter int unsigned T1L_CYC      = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [BITS_PER_LED-1:0] data_i,
  input  logic                    high_phase_i,
  input  logic                    low_phase_i,
  output logic                    high_done_o,
  output logic                    bit_done_o,
  output logic                    pixel_done_o
);

  localparam int unsigned TMAX_HI = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
  localparam int unsigned TMAX_LO = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
  localparam int unsigned TMAX    = (TMAX_HI > TMAX_LO) ? TMAX_HI : TMAX_LO;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(BITS_PER_LED + 1);

  localparam logic [TW-1:0] T0H_LAST = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T0L_LAST = TW'(T0L_CYC - 1);
  localparam logic [TW-1:0] T1H_LAST = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] T1L_LAST = TW'(T1L_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LED - 1);

  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    w_bit_val;
  logic [TW-1:0]           w_high_last;
  logic [TW-1:0]           w_low_last;

  assign w_bit_val   = shift_q[BITS_PER_LED-1];
  assign w_high_last = w_bit_val ? T1H_LAST : T0H_LAST;
  assign w_low_last  = w_bit_val ? T1L_LAST : T0L_LAST;

  assign high_done_o  = high_phase_i && (tmr_q == w_high_last);
  assign bit_done_o   = low_phase_i  && (tmr_q == w_low_last);
  assign pixel_done_o = bit_done_o   && (bit_cnt_q == BIT_LAST);

  always_comb begin
    shift_d   = shift_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      shift_d   = data_i;
      tmr_d     = '0;
      bit_cnt_d = '0;
    end else if (high_phase_i) begin
      tmr_d = high_done_o ? '0 : tmr_q + 1'b1;
    end else if (low_phase_i) begin
      if (bit_done_o) begin
        // The timer restarts so the next high phase begins from zero.
        tmr_d     = '0;
        shift_d   = {shift_q[BITS_PER_LED-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ws2812_chain_tx.sv
// ============================================================================
// ws2812_chain_tx : streamed-pixel WS2812 chain driver with latch gap
// Optional macro WS2812_BRIGHTNESS_EN adds a global brightness scaler.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module ws2812_chain_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FRE      = 27_000_000,
  parameter int unsigned LED_NUM      = 8,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned T0H_NS       = 400,
  parameter int unsigned T0L_NS       = 850,
  parameter int unsigned T1H_NS       = 850,
  parameter int unsigned T1L_NS       = 400,
  parameter int unsigned TRESET_US    = 80,
  parameter int unsigned COLOR_ORDER  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [BITS_PER_LED-1:0] pixel_data,
  input  logic                    pixel_valid,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  output logic                    pixel_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun,
  output logic                    WS2812_Di
);

  localparam int unsigned T0H_CYC = ns_to_cyc(64'(CLK_FRE), 64'(T0H_NS));
  localparam int unsigned T0L_CYC = ns_to_cyc(64'(CLK_FRE), 64'(T0L_NS));
  localparam int unsigned T1H_CYC = ns_to_cyc(64'(CLK_FRE), 64'(T1H_NS));
  localparam int unsigned T1L_CYC = ns_to_cyc(64'(CLK_FRE), 64'(T1L_NS));
  localparam int unsigned RST_CYC = us_to_cyc(64'(CLK_FRE), 64'(TRESET_US));

  localparam int PW = $clog2(LED_NUM + 1);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(LED_NUM - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

  ws_state_e               state_q, state_d;
  logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
  logic [RW-1:0]           gap_cnt_q, gap_cnt_d;
  logic                    di_q, di_d;
  logic                    done_q, done_d;

  logic [BITS_PER_LED-1:0] w_ordered;
  logic [BITS_PER_LED-1:0] w_pixel;
  logic [BITS_PER_LED-1:0] w_load_data;
  logic                    w_load;
  logic                    w_high_done;
  logic                    w_bit_done;
  logic                    w_pix_done;

  generate
    if (COLOR_ORDER == COLOR_ORDER_GRB && BITS_PER_LED >= 24) begin : g_grb
      // {R,G,B} on the top 24 bits becomes {G,R,B}; any extra low channel passes through.
      assign w_ordered = {pixel_data[BITS_PER_LED-9 -: 8],
                          pixel_data[BITS_PER_LED-1 -: 8],
                          pixel_data[BITS_PER_LED-17:0]};
    end else begin : g_asis
      assign w_ordered = pixel_data;
    end
  endgenerate

`ifdef WS2812_BRIGHTNESS_EN
  generate
    for (genvar gi = 0; gi < BITS_PER_LED / 8; gi++) begin : g_bright
      assign w_pixel[gi*8 +: 8] =
        8'((16'(w_ordered[gi*8 +: 8]) * (16'(brightness) + 16'd1)) >> 8);
    end
  endgenerate
`else
  assign w_pixel = w_ordered;
`endif

  assign w_load      = (state_q == S_LOAD);
  assign w_load_data = pixel_valid ? w_pixel : '0;

  assign pixel_ready = w_load;
  assign underrun    = w_load && !pixel_valid;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign WS2812_Di   = di_q;

  ws2812_bit_encoder #(
    .BITS_PER_LED (BITS_PER_LED),
    .T0H_CYC      (T0H_CYC),
    .T0L_CYC      (T0L_CYC),
    .T1H_CYC      (T1H_CYC),
    .T1L_CYC      (T1L_CYC)
  ) u_enc (
    .clk          (clk),
    .rst          (rst),
    .load_i       (w_load),
    .data_i       (w_load_data),
    .high_phase_i (state_q == S_BIT_HIGH),
    .low_phase_i  (state_q == S_BIT_LOW),
    .high_done_o  (w_high_done),
    .bit_done_o   (w_bit_done),
    .pixel_done_o (w_pix_done)
  );

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
        end
      end
      S_LOAD: state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (w_high_done) state_d = S_BIT_LOW;
      end
      S_BIT_LOW: begin
        if (w_pix_done) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = S_LATCH;
            gap_cnt_d = '0;
          end else begin
            state_d = S_LOAD;
          end
        end else if (w_bit_done) begin
          state_d = S_BIT_HIGH;
        end
      end
      S_LATCH: begin
        if (gap_cnt_q == RST_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line is registered from the next state so it tracks BIT_HIGH exactly.
  assign di_d = (state_d == S_BIT_HIGH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      gap_cnt_q <= '0;
      di_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      di_q      <= di_d;
      done_q    <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ws2812_chain_tx.sv
// ============================================================================
// tb_ws2812_chain_tx : cycle-level expected-waveform model plus literal checks
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_ws2812_chain_tx;

  localparam int T0H  = 11;
  localparam int T0L  = 23;
  localparam int T1H  = 23;
  localparam int T1L  = 11;
  localparam int RSTC = 2160;

  // Expected output vector per cycle: {Di, busy, ready, frame_done, underrun}
  localparam logic [4:0] E_IDLE     = 5'b00000;
  localparam logic [4:0] E_LOAD_OK  = 5'b01100;
  localparam logic [4:0] E_LOAD_UND = 5'b01101;
  localparam logic [4:0] E_HI       = 5'b11000;
  localparam logic [4:0] E_LO       = 5'b01000;
  localparam logic [4:0] E_DONE     = 5'b00010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready, busy, frame_done, underrun, WS2812_Di;

  logic        frame_start2 = 1'b0;
  logic        pixel_ready2, busy2, frame_done2, underrun2, di2;

  always #5 clk = ~clk;

  // Pixel source: a small table consumed one entry per handshake.
  logic [23:0] src [0:3];
  int          src_len = 0;
  int          src_off = 0;
  int          hs_cnt  = 0;

  always_comb begin
    pixel_valid = 1'b0;
    pixel_data  = 24'h0;
    if ((hs_cnt - src_off) < src_len) begin
      pixel_valid = 1'b1;
      pixel_data  = src[hs_cnt - src_off];
    end
  end

  always @(posedge clk) begin
    if (!rst && pixel_valid && pixel_ready) hs_cnt <= hs_cnt + 1;
  end

  ws2812_chain_tx #(.LED_NUM(2), .COLOR_ORDER(0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness  (8'd255),
`endif
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .WS2812_Di   (WS2812_Di)
  );

  ws2812_chain_tx #(.LED_NUM(1), .COLOR_ORDER(1)) u_dut_co (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start2),
    .pixel_data  (24'hFF0000),
    .pixel_valid (1'b1),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness  (8'd255),
`endif
    .pixel_ready (pixel_ready2),
    .busy        (busy2),
    .frame_done  (frame_done2),
    .underrun    (underrun2),
    .WS2812_Di   (di2)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Builds the whole expected waveform of one 2-pixel frame from the timing rules.
  logic [4:0] exp_q [$];

  function automatic void push_frame();
    int          idx;
    logic [23:0] v;
    idx = hs_cnt - src_off;
    for (int p = 0; p < 2; p++) begin
      if (idx < src_len) begin
        v = src[idx];
        idx++;
        exp_q.push_back(E_LOAD_OK);
      end else begin
        v = 24'h0;
        exp_q.push_back(E_LOAD_UND);
      end
      for (int b = 23; b >= 0; b--) begin
        for (int k = 0; k < (v[b] ? T1H : T0H); k++) exp_q.push_back(E_HI);
        for (int k = 0; k < (v[b] ? T1L : T0L); k++) exp_q.push_back(E_LO);
      end
    end
    for (int k = 0; k < RSTC; k++) exp_q.push_back(E_LO);
    exp_q.push_back(E_DONE);
  endfunction

  logic       chk_en = 1'b0;
  logic [4:0] e_now, a_now;

  always @(negedge clk) begin
    if (chk_en) begin
      e_now = (exp_q.size() > 0) ? exp_q.pop_front() : E_IDLE;
      a_now = {WS2812_Di, busy, pixel_ready, frame_done, underrun};
      n_checks++;
      if (a_now !== e_now) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t {di,busy,rdy,done,und} got %b expected %b",
                 $time, a_now, e_now);
      end
      if (rst) exp_q.delete();
      else if (exp_q.size() == 0 && frame_start) push_frame();
    end
  end

  // Observation counters for the literal checks.
  int   rises = 0, hi_cyc = 0, dones = 0, unds = 0, busy_cyc = 0, cur_w = 0;
  int   widths [$];
  logic prev_di = 1'b0;

  always @(negedge clk) begin
    if (WS2812_Di === 1'b1) begin
      hi_cyc++;
      cur_w++;
      if (prev_di !== 1'b1) rises++;
    end else if (prev_di === 1'b1) begin
      widths.push_back(cur_w);
      cur_w = 0;
    end
    if (frame_done === 1'b1) dones++;
    if (underrun === 1'b1)   unds++;
    if (busy === 1'b1)       busy_cyc++;
    prev_di = WS2812_Di;
  end

  int          cur2 = 0, nbits2 = 0, dones2 = 0;
  logic [23:0] dec2 = 24'h0;
  logic        prev2 = 1'b0;

  always @(negedge clk) begin
    if (di2 === 1'b1) cur2++;
    else if (prev2 === 1'b1) begin
      dec2   = {dec2[22:0], (cur2 > 17)};
      nbits2++;
      cur2   = 0;
    end
    if (frame_done2 === 1'b1) dones2++;
    prev2 = di2;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0) && n < 20000) begin
      tick(1);
      n++;
    end
    check({name, "_idle_timeout"}, int'(n >= 20000), 0);
  endtask

  task automatic start_frame(input int hold);
    frame_start = 1'b1;
    tick(hold);
    frame_start = 1'b0;
  endtask

  int r0, h0, hs0, d0, u0, b0, w0;

  task automatic snap();
    r0 = rises; h0 = hi_cyc; hs0 = hs_cnt; d0 = dones; u0 = unds;
    b0 = busy_cyc; w0 = widths.size();
  endtask

  initial begin
    int n;
    tick(3);
    check("reset_di",    int'(WS2812_Di),   0);
    check("reset_busy",  int'(busy),        0);
    check("reset_ready", int'(pixel_ready), 0);
    check("reset_done",  int'(frame_done),  0);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);

    // Frame 1: 0x800001 then 0x000000.
    src[0] = 24'h800001; src[1] = 24'h000000; src_len = 2; src_off = hs_cnt;
    snap();
    start_frame(1);
    wait_idle("f1");
    check("f1_pulses",   rises - r0, 48);
    check("f1_hi_cyc",   hi_cyc - h0, 552);
    check("f1_hs",       hs_cnt - hs0, 2);
    check("f1_done",     dones - d0, 1);
    check("f1_busy_cyc", busy_cyc - b0, 3794);
    check("f1_w_bit23",  widths[w0], 23);
    check("f1_w_bit22",  widths[w0+1], 11);
    check("f1_w_bit0",   widths[w0+23], 23);
    check("f1_w_p1b23",  widths[w0+24], 11);
    tick(5);

    // Frame 2: only one pixel available, second LOAD underruns.
    src[0] = 24'h800001; src_len = 1; src_off = hs_cnt;
    snap();
    start_frame(1);
    wait_idle("f2");
    check("f2_hs",      hs_cnt - hs0, 1);
    check("f2_und",     unds - u0, 1);
    check("f2_pulses",  rises - r0, 48);
    check("f2_hi_cyc",  hi_cyc - h0, 552);
    check("f2_w_last",  widths[w0+47], 11);
    check("f2_done",    dones - d0, 1);
    tick(5);

    // Frame 3: start held 3 cycles, extra request mid-frame is ignored.
    src[0] = 24'hA5A5A5; src[1] = 24'h5A5A5A; src_len = 2; src_off = hs_cnt;
    snap();
    start_frame(3);
    tick(200);
    start_frame(1);
    wait_idle("f3");
    tick(50);
    check("f3_done",   dones - d0, 1);
    check("f3_hs",     hs_cnt - hs0, 2);
    check("f3_hi_cyc", hi_cyc - h0, 816);
    check("f3_busy",   int'(busy), 0);

    // Frame 4: reset during the first high phase of pixel 1, then a clean frame.
    src[0] = 24'hFFFFFF; src[1] = 24'h123456; src_len = 2; src_off = hs_cnt;
    snap();
    start_frame(1);
    n = 0;
    while ((hs_cnt - hs0) < 2 && n < 5000) begin
      tick(1);
      n++;
    end
    check("f4_hs_timeout", int'(n >= 5000), 0);
    tick(3);
    check("f4_pre_rst_di", int'(WS2812_Di), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("f4_rst_di",   int'(WS2812_Di), 0);
    check("f4_rst_busy", int'(busy), 0);
    tick(10);
    check("f4_no_done",  dones - d0, 0);
    src_off = hs_cnt;
    snap();
    start_frame(1);
    wait_idle("f4b");
    check("f4b_hs",     hs_cnt - hs0, 2);
    check("f4b_done",   dones - d0, 1);
    check("f4b_pulses", rises - r0, 48);
    tick(5);

    // Colour-order instance: red in, green-position bits out.
    frame_start2 = 1'b1;
    tick(1);
    frame_start2 = 1'b0;
    n = 0;
    while (dones2 == 0 && n < 6000) begin
      tick(1);
      n++;
    end
    check("co_timeout", int'(n >= 6000), 0);
    check("co_bits",    nbits2, 24);
    check("co_word",    int'(dec2), 32'h00FF00);
    check("co_done",    dones2, 1);
    tick(5);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
